// File: rtl/inst_cache_ctrl.sv
// Control FSM for a 4-way, 8-set instruction cache: read hits, miss line fills,
// one-line-ahead prefetch, tree-PLRU replacement and saturating event counters.
module inst_cache_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    output logic             mem_resp,
    output logic             pmem_read,
    input  logic             pmem_resp,
    input  logic [3:0]       hits,
    input  logic             prefetch,
    input  logic [2:0]       lru_array,
    output logic [2:0]       next_lru_array,
    output logic             load_way,
    output logic [1:0]       load_way_sel,
    output logic             prefetch_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] pf_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MISS    = 2'd1,
        PF_FILL = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] pf_cnt_q, pf_cnt_d;
    logic             hit_ev, miss_ev, pf_ev;
    logic [1:0]       victim;

    // PLRU bit 0 picks the half, bits 1/2 pick the way inside it.
    function automatic logic [1:0] plru_victim(input logic [2:0] lru);
        if (lru[0]) begin
            return lru[2] ? 2'd3 : 2'd2;
        end
        return lru[1] ? 2'd1 : 2'd0;
    endfunction

    // Point the tree away from the way just used; the other subtree bit is kept.
    function automatic logic [2:0] plru_touch(input logic [2:0] lru, input logic [1:0] way);
        logic [2:0] t;
        t = lru;
        unique case (way)
            2'd0:    t = {lru[2], 1'b1, 1'b1};
            2'd1:    t = {lru[2], 1'b0, 1'b1};
            2'd2:    t = {1'b1, lru[1], 1'b0};
            default: t = {1'b0, lru[1], 1'b0};
        endcase
        return t;
    endfunction

    function automatic logic [1:0] first_way(input logic [3:0] h);
        if (h[0]) return 2'd0;
        if (h[1]) return 2'd1;
        if (h[2]) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign victim = plru_victim(lru_array);

    always_comb begin
        state_d        = state_q;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        load_way       = 1'b0;
        load_way_sel   = 2'd0;
        prefetch_ready = 1'b0;
        next_lru_array = lru_array;
        hit_ev         = 1'b0;
        miss_ev        = 1'b0;
        pf_ev          = 1'b0;

        // Reset masks every output so a coinciding pmem_resp cannot load a way.
        if (rst) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_read) begin
                        if (|hits) begin
                            mem_resp       = 1'b1;
                            next_lru_array = plru_touch(lru_array, first_way(hits));
                            hit_ev         = 1'b1;
                            if (prefetch) begin
                                state_d = PF_FILL;
                            end
                        end else begin
                            miss_ev = 1'b1;
                            state_d = MISS;
                        end
                    end
                end
                MISS: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_way       = 1'b1;
                        load_way_sel   = victim;
                        next_lru_array = plru_touch(lru_array, victim);
                        state_d        = IDLE;
                    end
                end
                PF_FILL: begin
                    prefetch_ready = 1'b1;
                    pmem_read      = 1'b1;
                    if (pmem_resp) begin
                        load_way       = 1'b1;
                        load_way_sel   = victim;
                        next_lru_array = plru_touch(lru_array, victim);
                        pf_ev          = 1'b1;
                        state_d        = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        hit_cnt_d  = hit_ev  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
        miss_cnt_d = miss_ev ? sat_inc(miss_cnt_q) : miss_cnt_q;
        pf_cnt_d   = pf_ev   ? sat_inc(pf_cnt_q)   : pf_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            pf_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            pf_cnt_q   <= pf_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign pf_cnt   = pf_cnt_q;

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Bench for inst_cache_ctrl: a small tag/PLRU store and line memory stand in for the
// datapath, and a cycle model of the cache rules is compared against every output.
module tb_inst_cache_ctrl;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    // Victim way for each PLRU value {b2,b1,b0}, worked out by hand from the tree rules.
    localparam logic [1:0] VICT [8] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, mem_read, mem_resp, pmem_read, pmem_resp;
    logic [3:0]       hits;
    logic             prefetch;
    logic [2:0]       lru_array, next_lru_array;
    logic             load_way;
    logic [1:0]       load_way_sel;
    logic             prefetch_ready;
    logic [CNT_W-1:0] hit_cnt, miss_cnt, pf_cnt;

    inst_cache_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_resp(pmem_resp), .hits(hits), .prefetch(prefetch),
        .lru_array(lru_array), .next_lru_array(next_lru_array), .load_way(load_way),
        .load_way_sel(load_way_sel), .prefetch_ready(prefetch_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .pf_cnt(pf_cnt)
    );

    // Datapath stand-in: 32-byte lines, set = addr[7:5], tag = addr[31:8].
    logic [23:0] tag_a [8][4];
    logic        vld_a [8][4];
    logic [2:0]  lru_a [8];
    logic [31:0] cpu_addr, pf_addr, idx_addr, succ;
    logic [2:0]  idx_set;
    logic        succ_hit, pf_en;
    int          lat;

    always_comb begin
        idx_addr = prefetch_ready ? pf_addr : cpu_addr;
        idx_set  = idx_addr[7:5];
        succ     = {cpu_addr[31:5] + 27'd1, 5'd0};
        hits     = 4'd0;
        succ_hit = 1'b0;
        for (int w = 0; w < 4; w++) begin
            hits[w] = vld_a[idx_set][w] && (tag_a[idx_set][w] == idx_addr[31:8]);
            if (vld_a[succ[7:5]][w] && (tag_a[succ[7:5]][w] == succ[31:8])) succ_hit = 1'b1;
        end
        prefetch  = pf_en && !succ_hit;
        lru_array = lru_a[idx_set];
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic env_clear();
        for (int s = 0; s < 8; s++) begin
            lru_a[s] = 3'd0;
            for (int w = 0; w < 4; w++) begin
                tag_a[s][w] = 24'd0;
                vld_a[s][w] = 1'b0;
            end
        end
    endtask

    // Array writes and pmem responses settle 1 time unit after each rising edge.
    initial begin
        logic       e_load, e_pfl;
        logic [1:0] e_sel;
        logic [2:0] e_nlru, e_set;
        logic [23:0] e_tag;
        logic [31:0] e_succ;
        int pcnt;
        pcnt = 0;
        forever begin
            @(posedge clk);
            e_load = load_way;  e_sel = load_way_sel; e_nlru = next_lru_array;
            e_set  = idx_set;   e_tag = idx_addr[31:8]; e_succ = succ;
            e_pfl  = mem_resp && prefetch && !rst;
            #1;
            lru_a[e_set] = e_nlru;
            if (e_load) begin
                tag_a[e_set][e_sel] = e_tag;
                vld_a[e_set][e_sel] = 1'b1;
            end
            if (e_pfl) pf_addr = e_succ;
            if (pmem_read) begin
                pcnt++;
                pmem_resp = (pcnt >= lat);
            end else begin
                pcnt = 0;
                pmem_resp = 1'b0;
            end
        end
    end

    // Cycle model: mode 0 = idle, 1 = fetching a missed line, 2 = fetching a prefetch line.
    bit         chk_en = 1'b0;
    int         mon_pmem, mon_loads;
    logic [1:0] mon_sel;

    function automatic logic [2:0] touch(input logic [2:0] lru, input int w);
        case (w)
            0:       return {lru[2], 2'b11};
            1:       return {lru[2], 2'b01};
            2:       return {1'b1, lru[1], 1'b0};
            default: return {1'b0, lru[1], 1'b0};
        endcase
    endfunction

    initial begin
        int m_mode, m_hit, m_miss, m_pf, nxt, w;
        logic e_resp, e_pr, e_prdy, e_load;
        logic [1:0] e_sel;
        logic [2:0] e_nlru;
        bit hit_ev, miss_ev, pf_ev;
        m_mode = 0; m_hit = 0; m_miss = 0; m_pf = 0;
        mon_pmem = 0; mon_loads = 0; mon_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                e_resp = 0; e_pr = 0; e_prdy = 0; e_load = 0; e_sel = 2'd0;
                e_nlru = lru_array; nxt = m_mode; hit_ev = 0; miss_ev = 0; pf_ev = 0;
                if (rst) begin
                    nxt = 0;
                end else if (m_mode == 0) begin
                    if (mem_read && hits != 4'd0) begin
                        w = 3;
                        for (int i = 3; i >= 0; i--) if (hits[i]) w = i;
                        e_resp = 1; e_nlru = touch(lru_array, w); hit_ev = 1;
                        if (prefetch) nxt = 2;
                    end else if (mem_read) begin
                        miss_ev = 1; nxt = 1;
                    end
                end else begin
                    e_pr = 1;
                    e_prdy = (m_mode == 2);
                    if (pmem_resp) begin
                        e_load = 1; e_sel = VICT[lru_array];
                        e_nlru = touch(lru_array, int'(e_sel));
                        pf_ev = (m_mode == 2); nxt = 0;
                    end
                end
                chk("mem_resp", mem_resp, e_resp);
                chk("pmem_read", pmem_read, e_pr);
                chk("prefetch_ready", prefetch_ready, e_prdy);
                chk("load_way", load_way, e_load);
                if (e_load || rst) chk("load_way_sel", load_way_sel, e_sel);
                chk("next_lru_array", next_lru_array, e_nlru);
                chk("hit_cnt", hit_cnt, m_hit);
                chk("miss_cnt", miss_cnt, m_miss);
                chk("pf_cnt", pf_cnt, m_pf);
                if (rst) begin
                    m_hit = 0; m_miss = 0; m_pf = 0;
                end else begin
                    if (hit_ev && m_hit < CMAX) m_hit++;
                    if (miss_ev && m_miss < CMAX) m_miss++;
                    if (pf_ev && m_pf < CMAX) m_pf++;
                end
                m_mode = nxt;
                if (pmem_read) mon_pmem++;
                if (load_way) begin
                    mon_loads++;
                    mon_sel = load_way_sel;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_read = 1'b0;
        tick();
        env_clear();
        tick();
        rst = 1'b0;
    endtask

    // CPU fetch held until mem_resp; returns the number of cycles including the response.
    task automatic req(input logic [31:0] addr, output int n);
        bit ok;
        cpu_addr = addr; mem_read = 1'b1; n = 0; ok = 0;
        while (n < 40 && !ok) begin
            @(negedge clk);
            n++;
            if (mem_resp) ok = 1;
        end
        @(posedge clk);
        #2;
        mem_read = 1'b0;
        chk("req_done", ok, 1'b1);
    endtask

    task automatic abort_req(input logic [31:0] addr);
        cpu_addr = addr; mem_read = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        rst = 1'b1; mem_read = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        bit seen;
        logic [31:0] a;
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0};
        rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b0; cpu_addr = 32'd0; pf_addr = 32'd0;
        pf_en = 1'b0; lat = 3;
        env_clear();
        tick(); tick();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_nlru", next_lru_array, 3'd0);
        tick();

        // Cold miss on 0x60 with a 5-cycle memory.
        do_reset(); lat = 5; mon_pmem = 0; mon_loads = 0;
        req(32'h60, n);
        chk("cold_cycles", n, 7);
        chk("cold_pmem_cycles", mon_pmem, 5);
        chk("cold_loads", mon_loads, 1);
        chk("cold_sel", mon_sel, 2'd0);
        chk("cold_lru", lru_a[3], 3'b011);
        chk("cold_miss_cnt", miss_cnt, 1);

        // Fill set 3 with tags 1..4, then tag 5 evicts way 0.
        do_reset(); lat = 2;
        for (int t = 1; t <= 5; t++) begin
            a = {t[23:0], 3'd3, 5'd0};
            req(a, n);
            chk("plru_sel", mon_sel, exp_sel[t-1]);
        end

        // Hit on 0x100 with 0x120 absent starts a prefetch; a read of 0x124 stalls behind it.
        do_reset(); lat = 3;
        req(32'h100, n);
        pf_en = 1'b1; lat = 4;
        req(32'h100, n);
        chk("pf_hit_cycles", n, 1);
        pf_en = 1'b0; mon_pmem = 0;
        req(32'h124, n);
        chk("pf_stall_cycles", n, 5);
        chk("pf_stall_pmem", mon_pmem, 4);
        chk("pf_cnt", pf_cnt, 1);
        mon_pmem = 0;
        req(32'h124, n);
        chk("pf_after_cycles", n, 1);
        chk("pf_after_pmem", mon_pmem, 0);

        // Reset landing on the pmem_resp cycle of a miss.
        do_reset(); lat = 3; mon_loads = 0;
        cpu_addr = 32'h200; mem_read = 1'b1; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (pmem_resp) seen = 1;
        end
        chk("rr_resp_seen", seen, 1'b1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk("rr_load_way", load_way, 1'b0);
        chk("rr_pmem_read", pmem_read, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_idle_pmem", pmem_read, 1'b0);
        chk("rr_idle_resp", mem_resp, 1'b0);
        chk("rr_no_load", mon_loads, 0);
        tick();

        // Hit counter saturation with a 4-bit counter.
        do_reset(); lat = 1;
        req(32'h60, n);
        repeat (14) req(32'h60, n);
        chk("sat_reach", hit_cnt, CMAX);
        req(32'h60, n);
        chk("sat_hold", hit_cnt, CMAX);

        // Random traffic over a small address pool, with occasional aborts.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            a = {24'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            lat = $urandom_range(1, 6);
            pf_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) abort_req(a);
            else req(a, n);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
